// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer: latches the result into a shadow HI/LO
// at issue and commits it after a fixed latency. Optional macro MD_EARLY_DONE_EN.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic        mf_sel,
  input  logic        md_use_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] rd_data
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic        busy_q, busy_d;

  logic        is_div, is_signed, neg_a, neg_b, b_zero, early;
  logic [31:0] mag_a, mag_b, div_b, uq, ur, quo, rem;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] res_hi, res_lo;

  // Signed divide runs on magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
  always_comb begin
    is_div    = md_op[1];
    is_signed = ~md_op[0];
    neg_a     = is_signed & src_a[31];
    neg_b     = is_signed & src_b[31];
    b_zero    = (src_b == '0);
    ext_a     = {{32{neg_a}}, src_a};
    ext_b     = {{32{neg_b}}, src_b};
    prod      = ext_a * ext_b;
    mag_a     = neg_a ? (~src_a + 32'd1) : src_a;
    mag_b     = neg_b ? (~src_b + 32'd1) : src_b;
    div_b     = b_zero ? 32'd1 : mag_b;
    uq        = mag_a / div_b;
    ur        = mag_a % div_b;
    quo       = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem       = neg_a ? (~ur + 32'd1) : ur;
    if (!is_div) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b_zero) begin
      res_hi = src_a;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
`ifdef MD_EARLY_DONE_EN
    early = ((src_a == '0) || b_zero) && !(is_div && b_zero);
`else
    early = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          sh_hi_d = res_hi;
          sh_lo_d = res_lo;
          if (early) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end else begin
            cnt_d   = is_div ? DIV_LOAD : MULT_LOAD;
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end else if (mt_we) begin
          if (mt_sel) hi_d = src_a;
          else        lo_d = src_a;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          hi_d    = sh_hi_q;
          lo_d    = sh_lo_q;
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign md_stall = md_use_d & (busy_q | md_start);
  assign rd_data  = mf_sel ? hi_q : lo_q;

endmodule
